console_ctrl: RTL



---
 rtl/console_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/console_ctrl.sv
// Text-console sequencer: turns accepted key codes into character-memory writes,
// keeps the cursor, and runs full-screen clear and one-row hardware scroll.
module console_ctrl #(
  parameter int COLS = 70,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  key_ascii,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic        clear_req,
  output logic        mem_we,
  output logic [11:0] mem_waddr,
  output logic [7:0]  mem_wdata,
  output logic [11:0] mem_raddr,
  input  logic [7:0]  mem_rdata,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);

  localparam logic [6:0] X_LAST = 7'(COLS - 1);
  localparam logic [4:0] Y_LAST = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    WRITE,
    SCROLL_CP,
    SCROLL_DRAIN,
    SCROLL_CLR
  } state_t;

  state_t      state_reg, state_next;
  logic [6:0]  cur_x_reg, cur_x_next;
  logic [4:0]  cur_y_reg, cur_y_next;
  logic [7:0]  key_reg, key_next;
  logic [6:0]  x_cnt_reg, x_cnt_next;
  logic [4:0]  y_cnt_reg, y_cnt_next;
  logic [11:0] cp_waddr_reg, cp_waddr_next;
  logic        cp_wvalid_reg, cp_wvalid_next;

  logic        we_c;
  logic [11:0] waddr_c;
  logic [7:0]  wdata_c;
  logic [11:0] raddr_c;
  logic        ready_c;

  logic key_is_print, key_is_nl, key_is_bs, in_is_nl;

  assign key_is_print = (key_reg >= 8'h20) && (key_reg <= 8'h7E);
  assign key_is_nl    = (key_reg == 8'h0A) || (key_reg == 8'h0D);
  assign key_is_bs    = (key_reg == 8'h08);
  assign in_is_nl     = (key_ascii == 8'h0A) || (key_ascii == 8'h0D);

  assign ready_c = (state_reg == IDLE) && !clear_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= CLEAR;
      cur_x_reg     <= '0;
      cur_y_reg     <= '0;
      key_reg       <= '0;
      x_cnt_reg     <= '0;
      y_cnt_reg     <= '0;
      cp_waddr_reg  <= '0;
      cp_wvalid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_x_reg     <= cur_x_next;
      cur_y_reg     <= cur_y_next;
      key_reg       <= key_next;
      x_cnt_reg     <= x_cnt_next;
      y_cnt_reg     <= y_cnt_next;
      cp_waddr_reg  <= cp_waddr_next;
      cp_wvalid_reg <= cp_wvalid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cur_x_next     = cur_x_reg;
    cur_y_next     = cur_y_reg;
    key_next       = key_reg;
    x_cnt_next     = x_cnt_reg;
    y_cnt_next     = y_cnt_reg;
    cp_waddr_next  = cp_waddr_reg;
    cp_wvalid_next = 1'b0;
    we_c           = 1'b0;
    waddr_c        = '0;
    wdata_c        = '0;
    raddr_c        = '0;

    case (state_reg)
      CLEAR: begin
        we_c    = 1'b1;
        waddr_c = {y_cnt_reg, x_cnt_reg};
        if (x_cnt_reg == X_LAST) begin
          x_cnt_next = '0;
          if (y_cnt_reg == Y_LAST) begin
            y_cnt_next = '0;
            cur_x_next = '0;
            cur_y_next = '0;
            state_next = IDLE;
          end else begin
            y_cnt_next = y_cnt_reg + 5'd1;
          end
        end else begin
          x_cnt_next = x_cnt_reg + 7'd1;
        end
      end

      IDLE: begin
        if (clear_req) begin
          x_cnt_next = '0;
          y_cnt_next = '0;
          state_next = CLEAR;
        end else if (key_valid) begin
          key_next = key_ascii;
          // Newline on the last row skips WRITE so the scroll starts at t+1.
          if (in_is_nl && (cur_y_reg == Y_LAST)) begin
            cur_x_next = '0;
            x_cnt_next = '0;
            if (ROWS > 1) begin
              y_cnt_next = 5'd1;
              state_next = SCROLL_CP;
            end else begin
              state_next = SCROLL_CLR;
            end
          end else begin
            state_next = WRITE;
          end
        end
      end

      WRITE: begin
        state_next = IDLE;
        if (key_is_print) begin
          we_c    = 1'b1;
          waddr_c = {cur_y_reg, cur_x_reg};
          wdata_c = key_reg;
          if (cur_x_reg < X_LAST) begin
            cur_x_next = cur_x_reg + 7'd1;
          end else begin
            cur_x_next = '0;
            if (cur_y_reg < Y_LAST) begin
              cur_y_next = cur_y_reg + 5'd1;
            end else begin
              x_cnt_next = '0;
              if (ROWS > 1) begin
                y_cnt_next = 5'd1;
                state_next = SCROLL_CP;
              end else begin
                state_next = SCROLL_CLR;
              end
            end
          end
        end else if (key_is_nl) begin
          cur_x_next = '0;
          if (cur_y_reg < Y_LAST) cur_y_next = cur_y_reg + 5'd1;
        end else if (key_is_bs) begin
          if (cur_x_reg != 7'd0) begin
            cur_x_next = cur_x_reg - 7'd1;
            we_c       = 1'b1;
            waddr_c    = {cur_y_reg, cur_x_reg - 7'd1};
          end else if (cur_y_reg != 5'd0) begin
            cur_x_next = X_LAST;
            cur_y_next = cur_y_reg - 5'd1;
            we_c       = 1'b1;
            waddr_c    = {cur_y_reg - 5'd1, X_LAST};
          end
        end
      end

      SCROLL_CP: begin
        // Read row y, write the previous cycle's read one row up.
        raddr_c        = {y_cnt_reg, x_cnt_reg};
        we_c           = cp_wvalid_reg;
        waddr_c        = cp_waddr_reg;
        wdata_c        = mem_rdata;
        cp_waddr_next  = {y_cnt_reg - 5'd1, x_cnt_reg};
        cp_wvalid_next = 1'b1;
        if (x_cnt_reg == X_LAST) begin
          x_cnt_next = '0;
          if (y_cnt_reg == Y_LAST) state_next = SCROLL_DRAIN;
          else                     y_cnt_next = y_cnt_reg + 5'd1;
        end else begin
          x_cnt_next = x_cnt_reg + 7'd1;
        end
      end

      SCROLL_DRAIN: begin
        we_c       = 1'b1;
        waddr_c    = cp_waddr_reg;
        wdata_c    = mem_rdata;
        x_cnt_next = '0;
        state_next = SCROLL_CLR;
      end

      SCROLL_CLR: begin
        we_c    = 1'b1;
        waddr_c = {Y_LAST, x_cnt_reg};
        if (x_cnt_reg == X_LAST) begin
          x_cnt_next = '0;
          cur_x_next = '0;
          cur_y_next = Y_LAST;
          state_next = IDLE;
        end else begin
          x_cnt_next = x_cnt_reg + 7'd1;
        end
      end

      default: begin
        x_cnt_next = '0;
        y_cnt_next = '0;
        state_next = CLEAR;
      end
    endcase
  end

  // While reset is held the bus shows its quiescent values.
  assign mem_we    = we_c && !reset;
  assign mem_waddr = reset ? 12'd0 : waddr_c;
  assign mem_wdata = reset ? 8'd0 : wdata_c;
  assign mem_raddr = reset ? 12'd0 : raddr_c;
  assign key_ready = ready_c && !reset;
  assign busy      = (state_reg != IDLE) || reset;
  assign cursor_x  = cur_x_reg;
  assign cursor_y  = cur_y_reg;

endmodule
